// File: rtl/uart_tx_fifo_if.sv
// Byte stream into the UART transmitter (valid/ready handshake).
//   tdata  : byte to transmit
//   tvalid : tdata valid
//   tready : sink can accept a byte this cycle
// A transfer occurs when tvalid && tready at a rising clock edge.
interface uart_tx_fifo_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO. Bytes are pushed over a
// valid/ready stream, buffered, and shifted out as 8N1 frames
// (start bit 0, 8 data bits LSB first, stop bit 1).
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   stream     : byte input stream (slave side)
//   tx         : serial line, idle high, registered
//   busy       : high while a frame is on the line, registered
//   fifo_level : bytes held in the FIFO, 0..FIFO_DEPTH, registered
module uart_tx_fifo #(
  parameter int unsigned CYCLES_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_tx_fifo_if.slave               stream,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned CNT_W = $clog2(CYCLES_PER_BIT);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [LW-1:0]    LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and pointers
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic          tready_q;
  logic [LW-1:0] level_d;

  // Transmitter state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d;
  logic             busy_d;

  logic push_c;
  logic pop_c;
  logic cnt_end_c;
  logic fifo_empty_c;

  assign stream.tready = tready_q;
  assign push_c        = stream.tvalid && tready_q;
  assign cnt_end_c     = (cnt_q == CNT_LAST);
  assign fifo_empty_c  = (fifo_level == '0);

  // Next FIFO level: a simultaneous push and pop leaves it unchanged
  always_comb begin
    level_d = fifo_level;
    unique case ({push_c, pop_c})
      2'b10:   level_d = fifo_level + LW'(1);
      2'b01:   level_d = fifo_level - LW'(1);
      default: level_d = fifo_level;
    endcase
  end

  // FIFO pointers, level and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_level <= '0;
      tready_q   <= 1'b1;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      fifo_level <= level_d;
      tready_q   <= (level_d != LEVEL_FULL);
    end
  end

  // FIFO storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= stream.tdata;
  end

  // Transmitter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
      busy    <= busy_d;
    end
  end

  // Next-state logic; the line level follows the current state one cycle later
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_c   = 1'b0;
    tx_d    = 1'b1;
    busy_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty_c) begin
          pop_c   = 1'b1;
          shift_d = mem[rd_ptr_q];
          cnt_d   = '0;
          state_d = START;
        end
      end

      START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
        if (cnt_end_c) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        tx_d   = shift_q[0];
        busy_d = 1'b1;
        if (cnt_end_c) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        if (cnt_end_c) begin
          cnt_d = '0;
          // Back-to-back: a waiting byte starts its frame with no idle gap
          if (!fifo_empty_c) begin
            pop_c   = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .CYCLES_PER_BIT (CPB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stream     (bus),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of accepted bytes plus the position inside the current frame
  logic [7:0] mq [$];
  bit         m_active;
  logic [7:0] m_cur;
  int         m_pos;
  logic       m_tx;
  logic       m_busy;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // bit i = i-th bit on the line
  } vec_t;

  vec_t tbl [6];

  function automatic logic frame_bit(logic [7:0] d, int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return d[idx-1];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_cur    = '0;
    m_pos    = 0;
    m_tx     = 1'b1;
    m_busy   = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc    = bus.tvalid && (mq.size() != DEPTH);
    m_busy = m_active;
    m_tx   = m_active ? frame_bit(m_cur, m_pos / CPB) : 1'b1;
    if (!m_active) begin
      if (mq.size() != 0) begin
        m_cur    = mq.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
    end else if (m_pos == FRAME - 1) begin
      if (mq.size() != 0) begin
        m_cur = mq.pop_front();
        m_pos = 0;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_pos++;
    end
    if (acc) mq.push_back(bus.tdata);
  endtask

  task automatic check_outputs();
    check("model_tx", 32'(tx), 32'(m_tx));
    check("model_busy", 32'(busy), 32'(m_busy));
    check("model_tready", 32'(bus.tready), 32'(mq.size() != DEPTH));
    check("model_level", 32'(fifo_level), 32'(mq.size()));
  endtask

  // One clock: model advances at the edge, outputs compared on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_idle();
    int budget;
    budget = 4000;
    while ((m_active || mq.size() != 0) && budget > 0) begin
      cycle();
      budget--;
    end
    check("drain_timeout", 32'(budget == 0), 32'd0);
    cycle();
  endtask

  task automatic push_one(logic [7:0] d);
    bus.tvalid = 1'b1;
    bus.tdata  = d;
    cycle();
    bus.tvalid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish, at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int accepted;
    int busy_cnt;
    int budget;

    tbl[0] = '{8'hA5, 10'b1101001010};
    tbl[1] = '{8'h00, 10'b1000000000};
    tbl[2] = '{8'hFF, 10'b1111111110};
    tbl[3] = '{8'h3C, 10'b1001111000};
    tbl[4] = '{8'h01, 10'b1000000010};
    tbl[5] = '{8'h80, 10'b1100000000};

    bus.tvalid = 1'b0;
    bus.tdata  = '0;
    model_reset();

    // Reset state
    for (int i = 0; i < 3; i++) cycle();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tready", 32'(bus.tready), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    cycle();

    // Single-byte frames from the table
    for (int v = 0; v < 6; v++) begin
      wait_idle();
      push_one(tbl[v].data);
      cycle();
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < CPB; c++) begin
          cycle();
          check("table_line_bit", 32'(tx), 32'(tbl[v].line[b]));
        end
      end
      cycle();
      check("table_busy_end", 32'(busy), 32'd0);
      check("table_level_end", 32'(fifo_level), 32'd0);
    end

    // Back-to-back frames: 00 then FF
    wait_idle();
    bus.tvalid = 1'b1;
    bus.tdata  = 8'h00;
    cycle();
    bus.tdata  = 8'hFF;
    cycle();
    bus.tvalid = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      cycle();
      if (busy) busy_cnt++;
    end
    check("b2b_busy_cycles", 32'(busy_cnt), 32'd80);

    // FIFO full: six bytes offered on consecutive cycles
    wait_idle();
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      bus.tvalid = 1'b1;
      bus.tdata  = 8'(8'h10 + k);
      if (bus.tready) accepted++;
      cycle();
    end
    bus.tvalid = 1'b0;
    check("full_accepted", 32'(accepted), 32'd5);
    check("full_tready", 32'(bus.tready), 32'd0);
    check("full_level", 32'(fifo_level), 32'd4);
    wait_idle();

    // Simultaneous push and pop at the end of a stop bit, level 2
    wait_idle();
    bus.tvalid = 1'b1;
    bus.tdata  = 8'h5A;
    cycle();
    bus.tdata  = 8'hC3;
    cycle();
    bus.tdata  = 8'h81;
    cycle();
    bus.tvalid = 1'b0;
    budget = 200;
    while (!(m_active && m_pos == FRAME - 1) && budget > 0) begin
      cycle();
      budget--;
    end
    check("simul_wait_timeout", 32'(budget == 0), 32'd0);
    check("simul_level_before", 32'(fifo_level), 32'd2);
    push_one(8'h96);
    check("simul_level_after", 32'(fifo_level), 32'd2);
    wait_idle();

    // Mid-frame reset during data bit 3 of 8'h3C with two bytes buffered
    wait_idle();
    push_one(8'h3C);
    cycle();
    bus.tvalid = 1'b1;
    bus.tdata  = 8'h11;
    cycle();
    bus.tdata  = 8'h22;
    cycle();
    bus.tvalid = 1'b0;
    budget = 200;
    while (!(m_active && (m_pos / CPB) == 4) && budget > 0) begin
      cycle();
      budget--;
    end
    check("midrst_wait_timeout", 32'(budget == 0), 32'd0);
    check("midrst_level_before", 32'(fifo_level), 32'd2);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_tready", 32'(bus.tready), 32'd1);
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      check("midrst_idle_tx", 32'(tx), 32'd1);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      bus.tvalid = ($urandom_range(0, 15) < ((i / 500) % 2 == 0 ? 2 : 12));
      bus.tdata  = 8'($urandom);
      cycle();
    end
    bus.tvalid = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Serial transmit end of the team's UART link: accepts bytes over a valid/ready stream and buffers them in a small FIFO.
- Shifts each byte out as an 8N1 frame on a single line, one start bit, 8 data bits LSB first, one stop bit.
- Counterpart to the team's UART receiver; its testbench is a VUnit SystemVerilog bench with parameters overridden from the run script.

Parameters:
CYCLES_PER_BIT, 434, clk cycles per serial bit; legal >= 2
FIFO_DEPTH, 4, bytes buffered; power of two, legal 2..16

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset; deasserted synchronously to clk by the system
tdata  input  8  byte to transmit
tvalid  input  1  tdata valid
tready  output  1  high when FIFO not full; transfer occurs when tvalid && tready at rising edge
tx  output  1  serial line, idle high; registered output
busy  output  1  high while a frame is on the line (states START, DATA, STOP)
fifo_level  output  $clog2(FIFO_DEPTH)+1  bytes currently in FIFO, 0..FIFO_DEPTH

Behaviour:
- Reset, asynchronous on rst_n low: tx=1, busy=0, tready=1, fifo_level=0, FSM=IDLE, bit and cycle counters=0, FIFO pointers=0. Reset mid-frame aborts the frame; tx returns high immediately; buffered bytes are discarded.
- FIFO:
  - Circular buffer with wrapping pointers.
  - tready = (fifo_level != FIFO_DEPTH), derived from registered state.
  - Push on tvalid && tready.
  - Pop only on the FSM load event.
  - Simultaneous push and pop: level unchanged, both take effect; legal at any level except full.
  - When full, tvalid is ignored until a pop; tready rises the cycle after the pop.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if fifo_level != 0, pop head into shift register, cycle counter=0, enter START. tx stays high in IDLE.
  - START: tx=0 for CYCLES_PER_BIT cycles, then enter DATA with bit index 0.
  - DATA: tx=shift[0] for CYCLES_PER_BIT cycles per bit; shift right after each bit. After bit 7 completes, enter STOP.
  - STOP: tx=1 for CYCLES_PER_BIT cycles. At the end, if fifo_level != 0, pop and enter START directly (back-to-back, no idle gap); else enter IDLE.
- Latency: byte accepted at edge N into an empty FIFO with FSM in IDLE:
  - pop at edge N+1; tx falls after edge N+2 (registered tx), busy high from the same edge;
  - frame occupies exactly 10*CYCLES_PER_BIT cycles.
- Cycle counter width: $clog2(CYCLES_PER_BIT); wraps to 0 at CYCLES_PER_BIT-1.
- tdata captured only on an accepted push; changes to tdata while tready=0 have no effect.

Test Plan (bench overrides CYCLES_PER_BIT=4, FIFO_DEPTH=4):
- Reset check: hold rst_n low 3 cycles -> tx=1, busy=0, tready=1, fifo_level=0.
- Single byte: push 8'hA5 -> tx low 2 cycles after accept; line reads 0,1,0,1,0,0,1,0,1,1 each held 4 cycles (40 cycles total); busy falls afterwards; fifo_level back to 0.
- Back-to-back frames: push 8'h00, 8'hFF on consecutive cycles -> two frames with no high gap between the first stop bit and the second start bit; 80 cycles total busy.
- FIFO full: push 6 bytes with tvalid held high -> tready drops once fifo_level=4; exactly the first 5 bytes (1 in flight + 4 buffered) are accepted; all transmit in order; tready re-asserts the cycle after each pop.
- Mid-frame reset: assert rst_n low during DATA bit 3 of 8'h3C with 2 bytes buffered -> tx=1 immediately, fifo_level=0; after release, line stays idle high for 50 cycles.
- Simultaneous push and pop: FIFO level 2, push on the exact cycle of the STOP-end pop -> fifo_level stays 2; byte order is preserved on the line.
